uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link; the receive end of the same link the serial transmitter drives.
- Samples the asynchronous i_rx line, recovers start/data/stop bits at mid-bit, and presents each good byte with a one-cycle valid strobe.
- Sits between the board RX pin and any byte consumer, for example an echo path or a "Hello, world! " checker.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 102 ++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and framing-error detect
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_state_t               state, state_nxt;
  logic                      rx_s;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [7:0]                data_r;
  logic                      valid_r, err_r;
  logic                      sample;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_reset),
    .d   (i_rx),
    .q   (rx_s)
  );

  // Sample point: mid start bit, then one full bit period per data/stop bit.
  assign sample = ((state == START) && (cnt == CNT_HALF)) ||
                  (((state == DATA) || (state == STOP)) && (cnt == CNT_FULL));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (sample && (bit_idx == IDX_LAST)) state_nxt = STOP;
      STOP:    if (sample) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state != IDLE);
    o_data      = data_r;
    o_valid     = valid_r;
    o_frame_err = err_r;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      if (sample || (state == IDLE) || (state == BREAK)) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;
      if (sample) begin
        case (state)
          START: bit_idx <= '0;
          DATA: begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
          end
          STOP: begin
            if (rx_s) begin
              data_r  <= shreg;
              valid_r <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int CPB = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  always #5 i_clk = ~i_clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall = 0;

  // Monitor state, written only by the monitor process
  logic [7:0] got_q[$];
  int         valid_cyc_q[$];
  int         err_cnt = 0;
  int         overlap = 0;
  logic       prev_pulse = 1'b0;

  // Frame-level reference model
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  logic [7:0] exp_last = 8'h00;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid) begin
      got_q.push_back(o_data);
      valid_cyc_q.push_back(cyc);
    end
    if (o_frame_err) err_cnt <= err_cnt + 1;
    overlap <= overlap + ((o_valid && o_frame_err) ? 1 : 0)
                       + (((o_valid || o_frame_err) && prev_pulse) ? 1 : 0);
    prev_pulse <= o_valid || o_frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Bit edges are placed at rounded multiples of a fractional period so skew accumulates like a real clock offset.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per_x100);
    logic [9:0] bits;
    int t_prev, t_next;
    bits = {stop, b, 1'b0};
    t_prev = 0;
    last_fall = cyc;
    for (int k = 0; k < 10; k++) begin
      i_rx = bits[k];
      t_next = ((k + 1) * per_x100 + 50) / 100;
      tick(t_next - t_prev);
      t_prev = t_next;
    end
  endtask

  task automatic send_model(input logic [7:0] b, input logic stop, input int per_x100);
    send_frame(b, stop, per_x100);
    if (stop) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check_eq({tag, "_ferr"}, err_cnt, exp_err);
    check_eq({tag, "_overlap"}, overlap, 0);
    check_eq({tag, "_data"}, o_data, exp_last);
    check_eq({tag, "_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    string hello;
    int lat;
    int per;
    logic stop;

    i_reset = 1'b1;
    i_rx    = 1'b1;
    tick(3);
    check_eq("rst_data", o_data, 8'h00);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_ferr", o_frame_err, 1'b0);
    check_eq("rst_busy", o_busy, 1'b0);
    i_reset = 1'b0;
    tick(4);

    // Single byte and its latency from the line's falling edge
    send_model(8'h48, 1'b1, CPB * 100);
    tick(CPB);
    check_eq("single_seen", valid_cyc_q.size(), 1);
    if (valid_cyc_q.size() > 0) begin
      lat = valid_cyc_q[$] - last_fall;
      check_eq("single_latency", (lat >= 150 && lat <= 157), 1'b1);
    end
    compare_all("single");

    // Short low glitch is rejected at the mid-start sample
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(3);
    check_eq("glitch_busy_mid", o_busy, 1'b1);
    tick(20);
    compare_all("glitch");

    // Framing error followed by a held-low line
    send_model(8'h55, 1'b0, CPB * 100);
    tick(40);
    check_eq("ferr_busy_held", o_busy, 1'b1);
    check_eq("ferr_data_kept", o_data, exp_last);
    i_rx = 1'b1;
    tick(4);
    compare_all("ferr");

    // Back-to-back stream
    hello = "Hello, world! ";
    for (int i = 0; i < hello.len(); i++) send_model(hello[i], 1'b1, CPB * 100);
    tick(CPB);
    check_eq("stream_len", hello.len(), 14);
    compare_all("stream");

    // Reset part-way through a frame of 0xFF
    i_rx = 1'b0;
    tick(CPB);
    i_rx = 1'b1;
    tick(3 * CPB);
    #3;
    i_reset = 1'b1;
    #1;
    check_eq("mid_rst_data", o_data, 8'h00);
    check_eq("mid_rst_valid", o_valid, 1'b0);
    check_eq("mid_rst_ferr", o_frame_err, 1'b0);
    check_eq("mid_rst_busy", o_busy, 1'b0);
    exp_last = 8'h00;
    tick(2);
    i_reset = 1'b0;
    tick(4);
    send_model(8'hA5, 1'b1, CPB * 100);
    tick(CPB);
    compare_all("after_rst");

    // Transmitter clock 3% slow and 3% fast
    send_model(8'hC3, 1'b1, CPB * 103);
    tick(CPB);
    send_model(8'h3C, 1'b1, CPB * 97);
    tick(CPB);
    send_model(8'h3C, 1'b1, CPB * 103);
    send_model(8'hC3, 1'b1, CPB * 97);
    tick(CPB);
    compare_all("skew");

    // Random bytes, skew, gaps and occasional framing errors
    for (int n = 0; n < 40; n++) begin
      per  = $urandom_range(CPB * 97, CPB * 103);
      stop = ($urandom_range(0, 7) != 0);
      send_model(8'($urandom), stop, per);
      if (!stop) begin
        tick($urandom_range(0, 30));
        i_rx = 1'b1;
        tick(CPB);
      end else begin
        tick($urandom_range(0, 10));
      end
    end
    tick(CPB);
    compare_all("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
